// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Captures bytes from a UART receiver's level-type ready/rdout,
//               acknowledges each one, and buffers them in a FWFT FIFO with a
//               valid/ready read port and a sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_ready,
    input  logic [7:0]    rx_data,
    output logic          rx_ready_clr,
    output logic          m_valid,
    output logic [7:0]    m_data,
    input  logic          m_ready,
    output logic [AW:0]   count,
    output logic          full,
    output logic          overrun,
    input  logic          overrun_clr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

    state_t        r_state;
    logic          r_ready_clr;
    logic          r_overrun;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_mem [DEPTH];

    logic w_full;
    logic w_valid;
    logic w_pop;
    logic w_attempt;
    logic w_wr;
    logic w_drop;

    assign w_full    = (r_count == c_full_count);
    assign w_valid   = (r_count != '0);
    assign w_pop     = w_valid & m_ready;
    assign w_attempt = (r_state == S_IDLE) & rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_wr      = w_attempt & (~w_full | w_pop);
    assign w_drop    = w_attempt & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ready_clr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (rx_ready) begin
                        r_ready_clr <= 1'b1;
                        r_state     <= S_CLR;
                    end
                end
                S_CLR: begin
                    r_ready_clr <= 1'b0;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (!rx_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_ready_clr <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= rx_data;
        end
    end

    assign rx_ready_clr = r_ready_clr;
    assign m_valid      = w_valid;
    assign m_data       = r_mem[r_rptr];
    assign count        = r_count;
    assign full         = w_full;
    assign overrun      = r_overrun;

endmodule
`default_nettype wire
